// File: rtl/cordic_range_fold_if.sv
// Streaming port bundle for the cordic argument conditioner.
// The producer drives in_valid/theta_in; the conditioner drives the result fields.
interface cordic_range_fold_if;
   // Valid-only stream, no ready: a sample is taken on every posedge with
   // in_valid=1, and result fields are meaningful only while out_valid=1.
   logic        in_valid;
   logic [31:0] theta_in;
   logic        out_valid;
   logic [31:0] theta_out;
   logic        negate_out;
   logic        range_err;
   logic [15:0] err_count;

   modport master (
      output in_valid, theta_in,
      input  out_valid, theta_out, negate_out, range_err, err_count
   );

   modport slave (
      input  in_valid, theta_in,
      output out_valid, theta_out, negate_out, range_err, err_count
   );
endinterface

// File: rtl/cordic_range_fold.sv
// Folds an fp32 angle in [-pi, pi] into [-pi/2, pi/2] for the cordic cosine core,
// flagging results whose cosine must be negated downstream.

// fp32 adder: round-to-nearest-even, denormal inputs flushed to zero,
// result delayed through LATENCY output registers.
module fp_add #(
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        areset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] q
);
   logic [31:0]       big, sml, res;
   logic [7:0]        e_big, e_sml, diff;
   logic [23:0]       m_big, m_sml;
   logic [49:0]       sh;
   logic [26:0]       big_al, sml_al, norm;
   logic [27:0]       sum;
   logic              eff_sub, round_up;
   logic [4:0]        lz;
   logic signed [9:0] exp_n;
   logic [23:0]       mant_r;
   logic [31:0]       pipe_q [LATENCY];
   logic [31:0]       pipe_d [LATENCY];

   always_comb begin
      big    = (a[30:0] >= b[30:0]) ? a : b;
      sml    = (a[30:0] >= b[30:0]) ? b : a;
      e_big  = big[30:23];
      e_sml  = sml[30:23];
      m_big  = (e_big != 8'd0) ? {1'b1, big[22:0]} : 24'd0;
      m_sml  = (e_sml != 8'd0) ? {1'b1, sml[22:0]} : 24'd0;
      diff   = e_big - e_sml;
      eff_sub = big[31] ^ sml[31];
      sh     = {m_sml, 26'd0} >> diff;
      big_al = {m_big, 3'b000};
      // Alignment keeps guard/round bits plus a sticky bit for everything shifted out.
      if (diff > 8'd26) sml_al = {26'd0, |m_sml};
      else              sml_al = {sh[49:24], |sh[23:0]};
      if (eff_sub) sum = {1'b0, big_al} - {1'b0, sml_al};
      else         sum = {1'b0, big_al} + {1'b0, sml_al};
      lz = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (sum[i]) lz = 5'(26 - i);
      end
      if (sum[27]) begin
         norm  = {sum[27:2], sum[1] | sum[0]};
         exp_n = $signed({2'b00, e_big}) + 10'sd1;
      end else begin
         norm  = sum[26:0] << lz;
         exp_n = $signed({2'b00, e_big}) - $signed({5'd0, lz});
      end
      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant_r   = {1'b0, norm[25:3]} + {23'd0, round_up};
      if (mant_r[23]) exp_n = exp_n + 10'sd1;
      if (e_big == 8'hFF)          res = big;
      else if (sum == 28'd0)       res = {big[31] & ~eff_sub, 31'd0};
      else if (exp_n <= 10'sd0)    res = {big[31], 31'd0};
      else if (exp_n >= 10'sd255)  res = {big[31], 8'hFF, 23'd0};
      else                         res = {big[31], exp_n[7:0], mant_r[22:0]};
   end

   always_comb begin
      pipe_d[0] = res;
      for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= 32'd0;
      end else begin
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
      end
   end

   assign q = pipe_q[LATENCY-1];
endmodule

module cordic_range_fold #(
   parameter int          ADD_LATENCY = 3,
   parameter logic [31:0] PI          = 32'h40490fdb,
   parameter logic [31:0] HALF_PI     = 32'h3fc90fdb
) (
   input  logic                 clk,
   input  logic                 reset,
   cordic_range_fold_if.slave   bus
);
   typedef enum logic [1:0] {CLS_PASS, CLS_FOLD, CLS_ERR} cls_e;

   logic        valid0_q, valid0_d;
   logic [31:0] theta0_q, theta0_d;
   cls_e        cls0;
   logic [31:0] add_a, add_b, add_q;

   logic        sb_valid_q [ADD_LATENCY];
   logic        sb_valid_d [ADD_LATENCY];
   cls_e        sb_cls_q   [ADD_LATENCY];
   cls_e        sb_cls_d   [ADD_LATENCY];
   logic [31:0] sb_theta_q [ADD_LATENCY];
   logic [31:0] sb_theta_d [ADD_LATENCY];

   logic        out_valid_q, out_valid_d;
   logic [31:0] theta_out_q, theta_out_d;
   logic        negate_q, negate_d;
   logic        range_err_q, range_err_d;
   logic [15:0] err_count_q, err_count_d;

   // Magnitude bits of an fp32 order like unsigned integers, so plain compares classify.
   always_comb begin
      cls0 = CLS_PASS;
      if (theta0_q[30:23] == 8'hFF || theta0_q[30:0] > PI[30:0]) cls0 = CLS_ERR;
      else if (theta0_q[30:0] > HALF_PI[30:0])                   cls0 = CLS_FOLD;
   end

   // sign(theta)*pi - theta
   assign add_a = {theta0_q[31], PI[30:0]};
   assign add_b = {~theta0_q[31], theta0_q[30:0]};

   fp_add #(.LATENCY(ADD_LATENCY)) u_fp_add (
      .clk    (clk),
      .areset (1'b0),
      .a      (add_a),
      .b      (add_b),
      .q      (add_q)
   );

   always_comb begin
      valid0_d      = bus.in_valid;
      theta0_d      = bus.theta_in;
      sb_valid_d[0] = valid0_q;
      sb_cls_d[0]   = cls0;
      sb_theta_d[0] = theta0_q;
      for (int i = 1; i < ADD_LATENCY; i++) begin
         sb_valid_d[i] = sb_valid_q[i-1];
         sb_cls_d[i]   = sb_cls_q[i-1];
         sb_theta_d[i] = sb_theta_q[i-1];
      end
   end

   // The side-band tail lines up with the adder output for the same sample.
   always_comb begin
      out_valid_d = sb_valid_q[ADD_LATENCY-1];
      theta_out_d = theta_out_q;
      negate_d    = negate_q;
      range_err_d = range_err_q;
      err_count_d = err_count_q;
      if (sb_valid_q[ADD_LATENCY-1]) begin
         case (sb_cls_q[ADD_LATENCY-1])
            CLS_FOLD: begin
               theta_out_d = add_q;
               negate_d    = 1'b1;
               range_err_d = 1'b0;
            end
            CLS_ERR: begin
               theta_out_d = 32'd0;
               negate_d    = 1'b0;
               range_err_d = 1'b1;
               if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            end
            default: begin
               theta_out_d = sb_theta_q[ADD_LATENCY-1];
               negate_d    = 1'b0;
               range_err_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid0_q    <= 1'b0;
         theta0_q    <= 32'd0;
         for (int i = 0; i < ADD_LATENCY; i++) begin
            sb_valid_q[i] <= 1'b0;
            sb_cls_q[i]   <= CLS_PASS;
            sb_theta_q[i] <= 32'd0;
         end
         out_valid_q <= 1'b0;
         theta_out_q <= 32'd0;
         negate_q    <= 1'b0;
         range_err_q <= 1'b0;
         err_count_q <= 16'd0;
      end else begin
         valid0_q    <= valid0_d;
         theta0_q    <= theta0_d;
         for (int i = 0; i < ADD_LATENCY; i++) begin
            sb_valid_q[i] <= sb_valid_d[i];
            sb_cls_q[i]   <= sb_cls_d[i];
            sb_theta_q[i] <= sb_theta_d[i];
         end
         out_valid_q <= out_valid_d;
         theta_out_q <= theta_out_d;
         negate_q    <= negate_d;
         range_err_q <= range_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.theta_out  = theta_out_q;
   assign bus.negate_out = negate_q;
   assign bus.range_err  = range_err_q;
   assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_cordic_range_fold.sv
// Scoreboard bench for cordic_range_fold: a real-arithmetic reference model
// predicts each folded angle, and outputs are matched in order with their arrival cycle.
module tb_cordic_range_fold;
   localparam logic [31:0] PI      = 32'h40490fdb;
   localparam logic [31:0] HALF_PI = 32'h3fc90fdb;
   localparam int          LAT     = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cordic_range_fold_if bus ();

   cordic_range_fold dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          model_errs = 0;
   logic        mon_en = 1'b0;
   logic [33:0] last_exp = '0;
   logic [33:0] exp_q[$];
   int          exp_cyc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic real pow2(input int k);
      real r = 1.0;
      if (k >= 0) repeat (k) r = r * 2.0;
      else        repeat (-k) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp32_to_real(input logic [30:0] m);
      if (m[30:23] == 8'd0) return real'(m[22:0]) * pow2(-149);
      return (1.0 + real'(m[22:0]) / 8388608.0) * pow2(int'(m[30:23]) - 127);
   endfunction

   // Exact for the fold results, which always fit a 24-bit significand.
   function automatic logic [30:0] real_to_fp32(input real v);
      real x = v;
      int  e = 127;
      longint f;
      if (v == 0.0) return 31'd0;
      while (x >= 2.0) begin x = x / 2.0; e++; end
      while (x < 1.0 && e > 1) begin x = x * 2.0; e--; end
      f = longint'((x - 1.0) * 8388608.0);
      return {8'(e), 23'(f)};
   endfunction

   // Packed as {range_err, negate, theta}.
   function automatic logic [33:0] model(input logic [31:0] th);
      real         v, pi_r, half_r;
      logic [30:0] mag;
      pi_r   = fp32_to_real(PI[30:0]);
      half_r = fp32_to_real(HALF_PI[30:0]);
      if (th[30:23] == 8'hFF) return {2'b10, 32'd0};
      v = fp32_to_real(th[30:0]);
      if (v > pi_r) return {2'b10, 32'd0};
      if (v > half_r) begin
         mag = real_to_fp32(pi_r - v);
         return {2'b01, (mag != 31'd0) & th[31], mag};
      end
      return {2'b00, th};
   endfunction

   task automatic drive(input logic [31:0] th);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.theta_in = th;
      exp_q.push_back(model(th));
      exp_cyc_q.push_back(cyc + LAT);
   endtask

   task automatic drive_unscored(input logic [31:0] th);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.theta_in = th;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.theta_in = $urandom;
      end
   endtask

   task automatic drain();
      int budget = 40;
      while (exp_q.size() != 0 && budget > 0) begin
         idle(1);
         budget--;
      end
      check_val("drain_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [31:0] rand_theta();
      logic [31:0] t;
      case ($urandom_range(0, 3))
         0: t = $urandom;
         1: t = ($urandom_range(0, 1) == 0)
               ? {1'b0, 8'd127, 23'($urandom_range(32'h490fdc, 32'h7fffff))}
               : {1'b0, 8'd128, 23'($urandom_range(32'h0, 32'h490fdb))};
         2: t = {1'b0, 8'($urandom_range(0, 127)), 23'($urandom)};
         default: t = {1'b0, 8'hFF, 23'($urandom_range(0, 3))};
      endcase
      t[31] = 1'($urandom_range(0, 1));
      return t;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
               last_exp = exp_q.pop_front();
               check_val("out_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
               check_val("theta_out", 64'(bus.theta_out), 64'(last_exp[31:0]));
               check_val("negate_out", 64'(bus.negate_out), 64'(last_exp[32]));
               check_val("range_err", 64'(bus.range_err), 64'(last_exp[33]));
               if (last_exp[33]) model_errs++;
               check_val("err_count", 64'(bus.err_count), 64'(model_errs));
            end
         end else begin
            check_val("hold_outputs", 64'({bus.range_err, bus.negate_out, bus.theta_out}),
                      64'(last_exp));
         end
      end
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.theta_in = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_val("rst_theta_out", 64'(bus.theta_out), 64'd0);
      check_val("rst_negate", 64'(bus.negate_out), 64'd0);
      check_val("rst_range_err", 64'(bus.range_err), 64'd0);
      check_val("rst_err_count", 64'(bus.err_count), 64'd0);
      mon_en = 1'b1;

      drive(32'h3f000000); idle(7);
      drive(32'h40000000); idle(7);
      check_val("fold_pos_2", 64'(bus.theta_out), 64'h3f921fb6);
      drive(32'hc0000000); idle(7);
      check_val("fold_neg_2", 64'(bus.theta_out), 64'hbf921fb6);
      drive(32'h40800000); drive(32'h7fc00000); idle(7);
      check_val("err_count_two", 64'(bus.err_count), 64'd2);

      drive(32'h3f000000); drive(32'h40000000); drive(32'hc0000000);
      drive(HALF_PI); drive(PI); drive(32'h40800000);
      idle(7);
      check_val("err_count_three", 64'(bus.err_count), 64'd3);

      drive(32'h80000000); drive(32'h00000001); drive(32'hc0490fdb);
      drive(32'h3fc90fdc); drive(32'h40490fdc); drive(32'hff800000);
      for (int i = 0; i < 60; i++) begin
         drive(rand_theta());
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      drain();

      drive_unscored(32'h40000000);
      drive_unscored(32'h40800000);
      drive_unscored(32'h3f000000);
      @(negedge clk);
      mon_en = 1'b0;
      bus.in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      last_exp = '0;
      model_errs = 0;
      check_val("rst2_out_valid", 64'(bus.out_valid), 64'd0);
      check_val("rst2_theta_out", 64'(bus.theta_out), 64'd0);
      check_val("rst2_negate", 64'(bus.negate_out), 64'd0);
      check_val("rst2_range_err", 64'(bus.range_err), 64'd0);
      check_val("rst2_err_count", 64'(bus.err_count), 64'd0);
      mon_en = 1'b1;
      idle(10);

      drive(32'h40000000); idle(1); drive(32'h7f800000);
      drain();
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
